// File: rtl/weight_serializer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : weight_serializer_pkg
//  Description : Shared constants, state encoding and helpers for the result
//                serializer (shared word width with the SGD core / loader).
//  Revision    : 1.0 - initial release
// ============================================================================
package weight_serializer_pkg;

    // Width of one weight word, common to the SGD core and the serial loader.
    localparam int WORD_W = 16;

    // Frame sync pattern sent ahead of every result frame.
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    // Bit-counter reload values per field.
    localparam logic [4:0] SYNC_BITS  = 5'd8;
    localparam logic [4:0] CNT_BITS   = 5'd4;
    localparam logic [4:0] WORD_BITS  = 5'd16;
    localparam logic [4:0] CSUM_BITS  = 5'd8;
    // STOP spans two tick edges: one drives the stop bit, the next closes the frame.
    localparam logic [4:0] STOP_TICKS = 5'd2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SYNC = 3'd1,
        CNT  = 3'd2,
        DATA = 3'd3,
        CSUM = 3'd4,
        STOP = 3'd5
    } state_t;

    // Checksum contribution of one word: high byte XOR low byte.
    function automatic logic [7:0] fold_word(input logic [15:0] w);
        return w[15:8] ^ w[7:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/weight_serializer_piso_shift16.sv
`default_nettype none
// ============================================================================
//  Module      : piso_shift16
//  Description : 16-bit parallel-in serial-out shift register, MSB first.
//                Load has priority over shift; shorter fields are loaded
//                MSB-aligned with zero padding below.
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_shift16 (
    input  logic        CLK,
    input  logic        RST,
    input  logic        load,
    input  logic        shift,
    input  logic [15:0] din,
    output logic        msb
);

    logic [15:0] data;

    // Parallel load or left shift; the MSB is always the next bit to send.
    always_ff @(posedge CLK) begin
        if (RST) begin
            data <= 16'h0000;
        end else if (load) begin
            data <= din;
        end else if (shift) begin
            data <= {data[14:0], 1'b0};
        end
    end

    assign msb = data[15];

endmodule
`default_nettype wire

// File: rtl/weight_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : weight_serializer
//  Description : Snapshots bias + weight vector on start and streams it as a
//                tick-paced frame: SYNC(8) FEAT(4) WORD0..WORDfeat(16 each)
//                CHK(8) then one stop bit. All outputs registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module weight_serializer
    import weight_serializer_pkg::*;
#(
    parameter int MAX_FEATURES = 15,
    parameter int WORD_W       = weight_serializer_pkg::WORD_W,
    parameter int DATA_WIDTH   = WORD_W * (MAX_FEATURES + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [3:0]            feat,
    input  logic [DATA_WIDTH-1:0] weights,
    input  logic                  tick,
    output logic                  sout,
    output logic                  busy,
    output logic                  frame_done
);

    // The snapshot always holds 16 word slots so the 4-bit index never
    // selects outside the vector; slots beyond MAX_FEATURES read as zero.
    localparam int SNAP_W = WORD_W * 16;

    state_t              state;
    logic [4:0]          bit_cnt;
    logic [3:0]          feat_q;
    logic [3:0]          word_idx;
    logic [SNAP_W-1:0]   snap;
    logic [7:0]          chk;

    logic                w_step;
    logic                w_last;
    logic                w_last_word;
    logic [3:0]          w_sel_idx;
    logic [15:0]         w_sel_word;
    logic [15:0]         w_load_val;
    logic                w_load;
    logic                w_shift;
    logic                w_msb;

    // Next-field selection and shift-register control.
    always_comb begin
        w_step      = tick && ((state == SYNC) || (state == CNT) ||
                               (state == DATA) || (state == CSUM));
        w_last      = (bit_cnt == 5'd1);
        w_last_word = (word_idx == feat_q);
        // CNT hands over to word 0; inside DATA the next word is idx+1.
        w_sel_idx   = (state == DATA) ? (word_idx + 4'd1) : 4'd0;
        if (int'(w_sel_idx) > MAX_FEATURES) begin
            w_sel_word = 16'h0000;
        end else begin
            w_sel_word = 16'(snap[int'(w_sel_idx) * WORD_W +: WORD_W]);
        end
        w_load_val  = 16'h0000;
        case (state)
            IDLE:    w_load_val = {SYNC_BYTE, 8'h00};
            SYNC:    w_load_val = {feat_q, 12'h000};
            CNT:     w_load_val = w_sel_word;
            DATA:    w_load_val = w_last_word ? {chk, 8'h00} : w_sel_word;
            default: w_load_val = 16'h0000;
        endcase
        w_load  = ((state == IDLE) && start) || (w_step && w_last);
        w_shift = w_step && !w_last;
    end

    piso_shift16 u_piso (
        .CLK   (CLK),
        .RST   (RST),
        .load  (w_load),
        .shift (w_shift),
        .din   (w_load_val),
        .msb   (w_msb)
    );

    // Frame sequencer: field counting, snapshot, checksum and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            bit_cnt    <= 5'd0;
            feat_q     <= 4'd0;
            word_idx   <= 4'd0;
            snap       <= '0;
            chk        <= 8'h00;
            sout       <= 1'b1;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    sout <= 1'b1;
                    if (start) begin
                        feat_q   <= feat;
                        snap     <= SNAP_W'(weights);
                        chk      <= 8'h00;
                        word_idx <= 4'd0;
                        bit_cnt  <= SYNC_BITS;
                        busy     <= 1'b1;
                        state    <= SYNC;
                    end
                end
                SYNC, CNT, DATA, CSUM: begin
                    if (tick) begin
                        sout <= w_msb;
                        if (w_last) begin
                            // The field just finished; the shift register is
                            // reloaded with the next field on this same edge.
                            case (state)
                                SYNC: begin
                                    bit_cnt <= CNT_BITS;
                                    state   <= CNT;
                                end
                                CNT: begin
                                    bit_cnt  <= WORD_BITS;
                                    word_idx <= 4'd0;
                                    chk      <= chk ^ fold_word(w_sel_word);
                                    state    <= DATA;
                                end
                                DATA: begin
                                    if (w_last_word) begin
                                        bit_cnt <= CSUM_BITS;
                                        state   <= CSUM;
                                    end else begin
                                        bit_cnt  <= WORD_BITS;
                                        word_idx <= word_idx + 4'd1;
                                        chk      <= chk ^ fold_word(w_sel_word);
                                    end
                                end
                                default: begin
                                    bit_cnt <= STOP_TICKS;
                                    state   <= STOP;
                                end
                            endcase
                        end else begin
                            bit_cnt <= bit_cnt - 5'd1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        sout <= 1'b1;
                        if (w_last) begin
                            bit_cnt    <= 5'd0;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            bit_cnt <= bit_cnt - 5'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    sout  <= 1'b1;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_weight_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_weight_serializer
//  Description : Self-checking bench for weight_serializer. Table of frame
//                vectors plus hand-written reset / snapshot / back-to-back runs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_weight_serializer;

    localparam int DW = 256;

    logic          CLK = 1'b0;
    logic          RST;
    logic          start;
    logic [3:0]    feat;
    logic [DW-1:0] weights;
    logic          tick;
    logic          sout;
    logic          busy;
    logic          frame_done;

    always #5 CLK = ~CLK;

    weight_serializer #(
        .MAX_FEATURES (15),
        .WORD_W       (16),
        .DATA_WIDTH   (DW)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .feat       (feat),
        .weights    (weights),
        .tick       (tick),
        .sout       (sout),
        .busy       (busy),
        .frame_done (frame_done)
    );

    typedef struct {
        logic [3:0]    feat;
        logic [DW-1:0] weights;
        int            period;
        logic [7:0]    chk;
    } vec_t;

    vec_t vecs [4];
    logic exp_q [$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_field(input logic [15:0] v, input int w);
        for (int i = w - 1; i >= 0; i--) exp_q.push_back(v[i]);
    endtask

    // One frame: scoreboard filled at launch, popped on every tick edge.
    task automatic run_frame(input int idx, input bit keep_start, input bit disturb, input int abort_at);
        vec_t       v;
        int         n_bits;
        int         ticks;
        int         budget;
        int         busy_cycles;
        logic [7:0] mchk;
        logic [7:0] rx_chk;
        logic       last_sout;
        logic       eb;
        logic [15:0] w;
        bit         finished;

        v = vecs[idx];
        exp_q.delete();
        mchk = 8'h00;
        push_field(16'h00A5, 8);
        push_field({12'h000, v.feat}, 4);
        for (int i = 0; i <= int'(v.feat); i++) begin
            w = v.weights[16*i +: 16];
            push_field(w, 16);
            mchk = mchk ^ w[15:8] ^ w[7:0];
        end
        push_field({8'h00, mchk}, 8);
        exp_q.push_back(1'b1);
        n_bits = exp_q.size() - 1;

        feat = v.feat; weights = v.weights; start = 1'b1; tick = 1'b0;
        cycle();
        if (!keep_start) start = 1'b0;
        check($sformatf("v%0d launch busy", idx), 32'(busy), 32'd1);
        check($sformatf("v%0d launch sout", idx), 32'(sout), 32'd1);

        busy_cycles = 1; ticks = 0; last_sout = 1'b1; finished = 0; rx_chk = 8'h00;
        budget = (n_bits + 2) * v.period + 10;
        for (int c = 1; c <= budget && !finished; c++) begin
            tick = ((c % v.period) == 0);
            if (disturb && c == 20) begin
                start = 1'b1; feat = 4'hF; weights = ~v.weights;
            end
            if (disturb && c == 21) start = 1'b0;
            cycle();
            if (busy) busy_cycles++;
            if (tick) begin
                ticks++;
                if (exp_q.size() > 0) begin
                    eb = exp_q.pop_front();
                    check($sformatf("v%0d bit%0d", idx, ticks), 32'(sout), 32'(eb));
                    check($sformatf("v%0d busy/done bit%0d", idx, ticks), 32'({busy, frame_done}), 32'd2);
                    if (ticks > n_bits - 8 && ticks <= n_bits) rx_chk = {rx_chk[6:0], sout};
                end else begin
                    check($sformatf("v%0d frame_done", idx), 32'(frame_done), 32'd1);
                    check($sformatf("v%0d busy fall", idx), 32'(busy), 32'd0);
                    check($sformatf("v%0d stop sout", idx), 32'(sout), 32'd1);
                    finished = 1;
                end
                if (abort_at > 0 && ticks == abort_at) begin
                    // Reset wins over a simultaneous start and tick.
                    RST = 1'b1; start = 1'b1; tick = 1'b1;
                    cycle();
                    check("abort {sout,busy,done}", 32'({sout, busy, frame_done}), 32'd4);
                    RST = 1'b0; start = 1'b0;
                    cycle();
                    check("abort stays idle", 32'({sout, busy, frame_done}), 32'd4);
                    exp_q.delete();
                    return;
                end
            end else begin
                check($sformatf("v%0d hold c%0d", idx, c), 32'(sout), 32'(last_sout));
            end
            last_sout = sout;
        end

        if (!finished) begin
            checks++;
            errors++;
            $display("FAIL v%0d timeout: no frame_done after %0d cycles, expected within budget", idx, budget);
        end else begin
            check($sformatf("v%0d chk byte", idx), 32'(rx_chk), 32'(v.chk));
            // With tick every cycle: start cycle + all frame bits + stop bit.
            if (v.period == 1)
                check($sformatf("v%0d busy cycles", idx), 32'(busy_cycles), 32'(n_bits + 2));
        end

        if (!keep_start) begin
            tick = 1'b1;
            cycle();
            check($sformatf("v%0d post idle", idx), 32'({sout, busy, frame_done}), 32'd4);
        end
        if (disturb) begin
            for (int k = 0; k < 8; k++) begin
                cycle();
                check("no queued second frame", 32'({sout, busy}), 32'd2);
            end
        end
    endtask

    initial begin
        // Vector table: feat, weights, tick period, expected checksum.
        vecs[0].feat = 4'd0; vecs[0].weights = '0; vecs[0].weights[15:0] = 16'h1234;
        vecs[0].period = 1; vecs[0].chk = 8'h26;
        vecs[1].feat = 4'd15; vecs[1].weights = '0;
        for (int i = 0; i < 16; i++) vecs[1].weights[16*i +: 16] = 16'(32'h0101 * i);
        vecs[1].period = 4; vecs[1].chk = 8'h00;
        vecs[2].feat = 4'd2; vecs[2].weights = '0;
        vecs[2].weights[15:0] = 16'hBEEF; vecs[2].weights[31:16] = 16'h00FF;
        vecs[2].weights[47:32] = 16'h8001;
        vecs[2].period = 2; vecs[2].chk = 8'h2F;
        vecs[3].feat = 4'd1; vecs[3].weights = '0;
        vecs[3].weights[15:0] = 16'hFFFF; vecs[3].weights[31:16] = 16'h1357;
        vecs[3].period = 1; vecs[3].chk = 8'h44;

        RST = 1'b1; start = 1'b0; tick = 1'b0; feat = 4'd0; weights = '0;
        for (int i = 0; i < 3; i++) begin
            tick  = (i % 2) == 0;
            start = (i % 2) == 1;
            cycle();
            check($sformatf("reset c%0d {sout,busy,done}", i), 32'({sout, busy, frame_done}), 32'd4);
        end
        RST = 1'b0; start = 1'b0; tick = 1'b0;
        cycle();
        check("idle after reset", 32'({sout, busy, frame_done}), 32'd4);

        // Table-driven frames; vector 2 also gets a mid-frame start and weight change.
        for (int k = 0; k < 4; k++) run_frame(k, 1'b0, k == 2, 0);

        // Reset during word 3 of the full frame, then a clean full frame.
        run_frame(1, 1'b0, 1'b0, 66);
        run_frame(1, 1'b0, 1'b0, 0);

        // Start held high across consecutive frames.
        run_frame(3, 1'b1, 1'b0, 0);
        run_frame(3, 1'b1, 1'b0, 0);
        run_frame(3, 1'b0, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
